// File: rtl/pad_stream.sv
`default_nettype none
// ============================================================================
//  Module      : pad_stream
//  Description : Wraps an unpadded raster stream of 64-bit channel-group
//                vectors with a one-pixel zero border on every side and
//                forwards the padded frame downstream. Border vectors are
//                generated locally and never consume input.
//  Revision    : 1.0 - initial release
// ============================================================================
module pad_stream #(
    parameter int DIM_W = 16,
    parameter int GRP_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIM_W-1:0] cfg_img_width,
    input  logic [DIM_W-1:0] cfg_img_height,
    input  logic [GRP_W-1:0] cfg_ci_groups,
    input  logic             start,
    input  logic [63:0]      s_pixel,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [63:0]      m_pixel,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             busy,
    output logic             frame_done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [DIM_W-1:0]   w_q, w_d;
    logic [DIM_W-1:0]   h_q, h_d;
    logic [GRP_W-1:0]   g_q, g_d;
    // Counters only need to reach W+1 / H+1; a full-scale W or H is unsupported.
    logic [DIM_W-1:0]   row_q, row_d;
    logic [DIM_W-1:0]   col_q, col_d;
    logic [GRP_W-1:0]   grp_q, grp_d;
    logic [63:0]        m_pixel_q, m_pixel_d;
    logic               m_valid_q, m_valid_d;
    logic               frame_done_q, frame_done_d;

    logic               w_slot_free;
    logic               w_interior;
    logic               w_run;
    logic               w_load;
    logic               w_grp_last;
    logic               w_col_last;
    logic               w_row_last;
    logic               w_cfg_zero;

    // Position classification and handshake qualifiers for the current slot.
    assign w_run       = (state_q == ST_RUN);
    assign w_slot_free = !m_valid_q || m_ready;
    assign w_interior  = (row_q != '0) && (row_q <= h_q) &&
                         (col_q != '0) && (col_q <= w_q);
    assign w_load      = w_run && w_slot_free && (!w_interior || s_valid);
    assign w_grp_last  = (grp_q == g_q - GRP_W'(1));
    assign w_col_last  = (col_q == w_q + DIM_W'(1));
    assign w_row_last  = (row_q == h_q + DIM_W'(1));
    assign w_cfg_zero  = (cfg_img_width == '0) || (cfg_img_height == '0) ||
                         (cfg_ci_groups == '0);

    assign s_ready     = w_run && w_interior && w_slot_free;
    assign m_pixel     = m_pixel_q;
    assign m_valid     = m_valid_q;
    assign busy        = (state_q != ST_IDLE);
    assign frame_done  = frame_done_q;

    // State register, latched configuration, position counters and output slot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            w_q          <= '0;
            h_q          <= '0;
            g_q          <= '0;
            row_q        <= '0;
            col_q        <= '0;
            grp_q        <= '0;
            m_pixel_q    <= '0;
            m_valid_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            w_q          <= w_d;
            h_q          <= h_d;
            g_q          <= g_d;
            row_q        <= row_d;
            col_q        <= col_d;
            grp_q        <= grp_d;
            m_pixel_q    <= m_pixel_d;
            m_valid_q    <= m_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Next-state logic: frame sequencing, raster walk and output slot loading.
    always_comb begin
        state_d      = state_q;
        w_d          = w_q;
        h_d          = h_q;
        g_d          = g_q;
        row_d        = row_q;
        col_d        = col_q;
        grp_d        = grp_q;
        frame_done_d = 1'b0;

        // A load always fills the slot; otherwise a downstream accept empties it.
        if (w_load) begin
            m_valid_d = 1'b1;
            m_pixel_d = w_interior ? s_pixel : 64'd0;
        end else begin
            m_valid_d = m_ready ? 1'b0 : m_valid_q;
            m_pixel_d = m_pixel_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    w_d     = cfg_img_width;
                    h_d     = cfg_img_height;
                    g_d     = cfg_ci_groups;
                    row_d   = '0;
                    col_d   = '0;
                    grp_d   = '0;
                    // A degenerate frame has nothing to emit; just report completion.
                    state_d = w_cfg_zero ? ST_DRAIN : ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_load) begin
                    if (w_grp_last) begin
                        grp_d = '0;
                        if (w_col_last) begin
                            col_d = '0;
                            row_d = row_q + DIM_W'(1);
                        end else begin
                            col_d = col_q + DIM_W'(1);
                        end
                    end else begin
                        grp_d = grp_q + GRP_W'(1);
                    end
                    if (w_grp_last && w_col_last && w_row_last) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Complete once the final vector has left or is leaving now.
                if (!m_valid_q || m_ready) begin
                    state_d      = ST_IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_pad_stream.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_pad_stream
//  Description : Directed, table-driven bench for pad_stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pad_stream;

    localparam int DIM_W  = 16;
    localparam int GRP_W  = 10;
    localparam int BUDGET = 3000;
    localparam logic [63:0] ONES = 64'h0101010101010101;
    localparam logic [63:0] TAG  = 64'hA5A5000000000000;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [DIM_W-1:0] cfg_img_width = '0;
    logic [DIM_W-1:0] cfg_img_height = '0;
    logic [GRP_W-1:0] cfg_ci_groups = '0;
    logic             start = 1'b0;
    logic [63:0]      s_pixel = '0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [63:0]      m_pixel;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic             busy;
    logic             frame_done;

    int checks = 0;
    int errors = 0;

    pad_stream #(.DIM_W(DIM_W), .GRP_W(GRP_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_img_width  (cfg_img_width),
        .cfg_img_height (cfg_img_height),
        .cfg_ci_groups  (cfg_ci_groups),
        .start          (start),
        .s_pixel        (s_pixel),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .m_pixel        (m_pixel),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .busy           (busy),
        .frame_done     (frame_done)
    );

    always #5 clk = ~clk;

    // One frame scenario and its hand-computed expectations.
    typedef struct {
        int          w;
        int          h;
        int          g;
        int          rdy_mode;   // 0: always ready, 1: 1,0,0,1 repeating
        int          data_mode;  // 0: all 8'h01, 1: tagged by input index
        bit          starve;     // drop s_valid for 20 cycles at position (1,1)
        bit          mid_start;  // extra start + config change while busy
        int          abort_at;   // reset after this many outputs, -1 = none
        int          exp_out;
        int          exp_data;
        int          chk_idx;
        logic [63:0] chk_val;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] src_data(input int mode, input int k);
        if (mode == 0) return ONES;
        return TAG | 64'(k);
    endfunction

    function automatic bit is_interior(input vec_t v, input int k);
        int pix, col, row;
        pix = k / v.g;
        col = pix % (v.w + 2);
        row = pix / (v.w + 2);
        return (row >= 1) && (row <= v.h) && (col >= 1) && (col <= v.w);
    endfunction

    // Expected padded vector number k of the frame.
    function automatic logic [63:0] model(input vec_t v, input int k);
        int grp, pix, col, row;
        grp = k % v.g;
        pix = k / v.g;
        col = pix % (v.w + 2);
        row = pix / (v.w + 2);
        if (!is_interior(v, k)) return 64'd0;
        return src_data(v.data_mode, ((row - 1) * v.w + (col - 1)) * v.g + grp);
    endfunction

    task automatic run_frame(input int ti, input vec_t v);
        int          in_idx, out_acc, data_cnt, zero_cnt, done_cnt, cyc, pend, total;
        int          starve_cnt, first_int;
        bit          starve_used, saw_low, aborted, prev_stall;
        logic [63:0] prev_pix;
        in_idx = 0; out_acc = 0; data_cnt = 0; zero_cnt = 0; done_cnt = 0; cyc = 0;
        starve_cnt = 0; starve_used = 0; saw_low = 0; aborted = 0; prev_stall = 0;
        prev_pix = '0;
        total     = (v.w + 2) * (v.h + 2) * v.g;
        first_int = ((v.w + 2) + 1) * v.g;

        @(negedge clk);
        cfg_img_width  = DIM_W'(v.w);
        cfg_img_height = DIM_W'(v.h);
        cfg_ci_groups  = GRP_W'(v.g);
        start = 1'b1;
        @(posedge clk);

        while (cyc < BUDGET && done_cnt == 0 && !aborted) begin
            @(negedge clk);
            start = 1'b0;
            if (v.mid_start && cyc == 10) begin
                start          = 1'b1;
                cfg_img_width  = DIM_W'(1);
                cfg_img_height = DIM_W'(1);
                cfg_ci_groups  = GRP_W'(3);
            end
            m_ready = (v.rdy_mode == 0) ? 1'b1 : ((cyc % 4) == 0 || (cyc % 4) == 3);
            pend = out_acc + (m_valid ? 1 : 0);
            if (v.starve && !starve_used && pend == first_int) begin
                starve_cnt  = 20;
                starve_used = 1;
            end
            s_valid = (starve_cnt == 0);
            if (starve_cnt > 0) starve_cnt--;
            s_pixel = src_data(v.data_mode, in_idx);

            if (v.abort_at >= 0 && out_acc >= v.abort_at) begin
                rst_n   = 1'b0;
                m_ready = 1'b1;
                s_valid = 1'b1;
                @(posedge clk);
                #1;
                check("rst_m_valid", 64'(m_valid), 64'd0);
                check("rst_m_pixel", m_pixel, 64'd0);
                check("rst_s_ready", 64'(s_ready), 64'd0);
                check("rst_busy", 64'(busy), 64'd0);
                check("rst_frame_done", 64'(frame_done), 64'd0);
                rst_n   = 1'b1;
                aborted = 1;
            end else begin
                #1;
                if (frame_done) done_cnt++;
                if (cyc == 0) begin
                    check("busy_after_start", 64'(busy), 64'd1);
                    check("m_valid_before_first_load", 64'(m_valid), 64'd0);
                end
                if (cyc == 1) check("first_output_latency", 64'(m_valid), 64'd1);
                if (!s_valid && m_valid == 1'b0) saw_low = 1;
                if (prev_stall) begin
                    check($sformatf("f%0d_hold_valid", ti), 64'(m_valid), 64'd1);
                    check($sformatf("f%0d_hold_pixel", ti), m_pixel, prev_pix);
                end
                if (s_ready && pend < total && !is_interior(v, pend))
                    check($sformatf("f%0d_s_ready_border_pos%0d", ti, pend), 64'(s_ready), 64'd0);
                if (m_valid && m_ready) begin
                    if (out_acc < total)
                        check($sformatf("f%0d_vec%0d", ti, out_acc), m_pixel, model(v, out_acc));
                    if (out_acc == v.chk_idx)
                        check($sformatf("f%0d_spot%0d", ti, out_acc), m_pixel, v.chk_val);
                    if (m_pixel == 64'd0) zero_cnt++;
                    else data_cnt++;
                    out_acc++;
                end
                if (s_valid && s_ready) in_idx++;
                prev_stall = m_valid && !m_ready;
                prev_pix   = m_pixel;
                @(posedge clk);
                cyc++;
            end
        end

        if (!aborted) begin
            check($sformatf("f%0d_busy_at_done", ti), 64'(busy), 64'd0);
            // Trailing idle cycles: nothing more may come out.
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                m_ready = 1'b1;
                s_valid = 1'b0;
                #1;
                if (frame_done) done_cnt++;
                if (m_valid) out_acc++;
            end
            check($sformatf("f%0d_out_count", ti), 64'(out_acc), 64'(v.exp_out));
            check($sformatf("f%0d_data_count", ti), 64'(data_cnt), 64'(v.exp_data));
            check($sformatf("f%0d_zero_count", ti), 64'(zero_cnt), 64'(v.exp_out - v.exp_data));
            check($sformatf("f%0d_in_count", ti), 64'(in_idx), 64'(v.w * v.h * v.g));
            check($sformatf("f%0d_frame_done_count", ti), 64'(done_cnt), 64'd1);
            if (v.starve) check($sformatf("f%0d_starve_m_valid_low", ti), 64'(saw_low), 64'd1);
        end
        s_valid = 1'b0;
    endtask

    initial begin
        //        w  h  g rdy dat stv mid abort out data idx val
        tbl[0] = '{6, 6, 1, 0, 0, 0, 0, -1, 64, 36,  9, ONES};
        tbl[1] = '{2, 2, 2, 0, 1, 0, 0, -1, 32,  8, 12, TAG | 64'd2};
        tbl[2] = '{6, 6, 1, 1, 0, 0, 0, -1, 64, 36,  9, ONES};
        tbl[3] = '{3, 2, 1, 0, 1, 1, 0, -1, 20,  6,  6, TAG};
        tbl[4] = '{6, 6, 1, 0, 0, 0, 1, -1, 64, 36, 63, 64'd0};
        tbl[5] = '{6, 6, 1, 0, 0, 0, 0, 30, 64, 36,  9, ONES};
        tbl[6] = '{6, 6, 1, 0, 0, 0, 0, -1, 64, 36,  9, ONES};
        tbl[7] = '{4, 3, 3, 1, 1, 0, 0, -1, 90, 36, 23, TAG | 64'd2};

        // Reset state.
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        s_valid = 1'b1;
        m_ready = 1'b1;
        #1;
        check("reset_m_valid", 64'(m_valid), 64'd0);
        check("reset_m_pixel", m_pixel, 64'd0);
        check("reset_s_ready", 64'(s_ready), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_frame_done", 64'(frame_done), 64'd0);
        s_valid = 1'b0;
        rst_n   = 1'b1;
        @(posedge clk);

        for (int t = 0; t < 8; t++) run_frame(t, tbl[t]);

        // Zero channel-group count: no output, frame_done on the second edge.
        @(negedge clk);
        cfg_img_width  = DIM_W'(6);
        cfg_img_height = DIM_W'(6);
        cfg_ci_groups  = '0;
        start   = 1'b1;
        s_valid = 1'b1;
        m_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        #1;
        check("zero_cfg_busy_e1", 64'(busy), 64'd1);
        check("zero_cfg_done_e1", 64'(frame_done), 64'd0);
        check("zero_cfg_valid_e1", 64'(m_valid), 64'd0);
        check("zero_cfg_s_ready_e1", 64'(s_ready), 64'd0);
        @(posedge clk);
        @(negedge clk);
        #1;
        check("zero_cfg_done_e2", 64'(frame_done), 64'd1);
        check("zero_cfg_busy_e2", 64'(busy), 64'd0);
        check("zero_cfg_valid_e2", 64'(m_valid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        #1;
        check("zero_cfg_done_e3", 64'(frame_done), 64'd0);
        s_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
